perceptron_ctrl: RTL and testbench

//  Host-packet sequencer for the perceptron core. Sits between the UART RX/TX byte

---
 rtl/perceptron_ctrl_if.sv | 43 ++++
 rtl/perceptron_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_perceptron_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_ctrl_if.sv
// ---------------------------------------------------------------------------
// perceptron_ctrl_if
//   Bundles every byte/handshake signal around the perceptron packet
//   sequencer: UART RX/TX byte streams, the weight/input register write port
//   and the calculation start/done handshake.
//
//   master modport : the sequencer (perceptron_ctrl)
//   slave  modport : the surrounding UART + perceptron datapath
//
//   rx_valid/rx_data      received byte pulse and value
//   tx_ready/tx_valid/tx_data  transmit handshake and byte
//   w_we/x_we/wr_idx/wr_data   weight/input register write port
//   calc_start/calc_done/calc_result  calculation handshake and 16-bit result
//   busy/pkt_err          status outputs
// ---------------------------------------------------------------------------
interface perceptron_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        w_we;
  logic        x_we;
  logic [1:0]  wr_idx;
  logic [7:0]  wr_data;
  logic        calc_start;
  logic        calc_done;
  logic [15:0] calc_result;
  logic        busy;
  logic        pkt_err;

  modport master (
    input  rx_valid, rx_data, tx_ready, calc_done, calc_result,
    output tx_valid, tx_data, w_we, x_we, wr_idx, wr_data,
           calc_start, busy, pkt_err
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, calc_done, calc_result,
    input  tx_valid, tx_data, w_we, x_we, wr_idx, wr_data,
           calc_start, busy, pkt_err
  );
endinterface

// File: rtl/perceptron_ctrl.sv
// ---------------------------------------------------------------------------
// perceptron_ctrl
//   Host-packet sequencer for the perceptron core. Decodes packets of the
//   form [ADDR][OPCODE][N_IN data bytes] arriving from the UART receiver,
//   writes weight (opcode 0) or input (opcode 1) registers, starts a
//   calculation after an input load and returns the 16-bit result as two
//   bytes (high first) over the UART transmitter.
//
//   Parameters:
//     ADDR     node address; packets for other nodes are skipped
//     N_IN     data bytes per packet
//     TIMEOUT  idle clk cycles tolerated between bytes of one packet
//
//   Ports:
//     clk   system clock
//     nRst  synchronous active-low reset
//     bus   perceptron_ctrl_if.master (RX/TX bytes, register writes,
//           calc handshake, busy, pkt_err)
// ---------------------------------------------------------------------------
module perceptron_ctrl #(
  parameter logic [7:0] ADDR    = 8'd100,
  parameter int         N_IN    = 4,
  parameter int         TIMEOUT = 100000
) (
  input  logic                    clk,
  input  logic                    nRst,
  perceptron_ctrl_if.master       bus
);

  typedef enum logic [2:0] {
    IDLE,
    OPC,
    DATA,
    SKIP,
    CALC,
    TXH,
    TXL
  } state_t;

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int SK_W = $clog2(N_IN + 2);

  localparam logic [1:0]      LAST_IDX  = 2'(N_IN - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [SK_W-1:0] SKIP_PKT  = SK_W'(N_IN + 1);
  localparam logic [SK_W-1:0] SKIP_DATA = SK_W'(N_IN);
  localparam logic [SK_W-1:0] SKIP_ONE  = SK_W'(1);

  state_t          state;
  logic [1:0]      idx;
  logic            is_input;
  logic [SK_W-1:0] skip_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            start_pend;
  logic [7:0]      tx_lo;

  // Single registered FSM. Strobe outputs default low every cycle so each
  // assignment below produces exactly a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state          <= IDLE;
      idx            <= '0;
      is_input       <= 1'b0;
      skip_cnt       <= '0;
      to_cnt         <= '0;
      start_pend     <= 1'b0;
      tx_lo          <= '0;
      bus.tx_valid   <= 1'b0;
      bus.tx_data    <= '0;
      bus.w_we       <= 1'b0;
      bus.x_we       <= 1'b0;
      bus.wr_idx     <= '0;
      bus.wr_data    <= '0;
      bus.calc_start <= 1'b0;
      bus.busy       <= 1'b0;
      bus.pkt_err    <= 1'b0;
    end else begin
      bus.w_we       <= 1'b0;
      bus.x_we       <= 1'b0;
      bus.calc_start <= 1'b0;
      bus.pkt_err    <= 1'b0;

      case (state)
        IDLE: begin
          to_cnt <= '0;
          idx    <= '0;
          if (bus.rx_valid) begin
            if (bus.rx_data == ADDR) begin
              state <= OPC;
            end else begin
              // Foreign packet: swallow its opcode plus all data bytes.
              state    <= SKIP;
              skip_cnt <= SKIP_PKT;
            end
          end
        end

        OPC, DATA, SKIP: begin
          if (bus.rx_valid) begin
            to_cnt <= '0;
            case (state)
              OPC: begin
                idx <= '0;
                if (bus.rx_data == 8'd0) begin
                  is_input <= 1'b0;
                  state    <= DATA;
                end else if (bus.rx_data == 8'd1) begin
                  is_input <= 1'b1;
                  state    <= DATA;
                end else begin
                  state       <= SKIP;
                  skip_cnt    <= SKIP_DATA;
                  bus.pkt_err <= 1'b1;
                end
              end

              DATA: begin
                if (is_input) begin
                  bus.x_we <= 1'b1;
                end else begin
                  bus.w_we <= 1'b1;
                end
                bus.wr_idx  <= idx;
                bus.wr_data <= bus.rx_data;
                if (idx == LAST_IDX) begin
                  idx <= '0;
                  if (is_input) begin
                    // calc_start goes out one cycle after the last x_we.
                    state      <= CALC;
                    start_pend <= 1'b1;
                    bus.busy   <= 1'b1;
                  end else begin
                    state <= IDLE;
                  end
                end else begin
                  idx <= idx + 2'd1;
                end
              end

              default: begin
                if (skip_cnt == SKIP_ONE) begin
                  state <= IDLE;
                end
                skip_cnt <= skip_cnt - SKIP_ONE;
              end
            endcase
          end else if (to_cnt == TO_LAST) begin
            // Inter-byte silence too long: abandon the packet. Registers
            // already written keep their values.
            state       <= IDLE;
            idx         <= '0;
            to_cnt      <= '0;
            bus.pkt_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        CALC: begin
          if (bus.rx_valid) begin
            bus.pkt_err <= 1'b1;
          end
          if (start_pend) begin
            start_pend     <= 1'b0;
            bus.calc_start <= 1'b1;
          end else if (bus.calc_done) begin
            tx_lo        <= bus.calc_result[7:0];
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= bus.calc_result[15:8];
            state        <= TXH;
          end
        end

        TXH: begin
          if (bus.rx_valid) begin
            bus.pkt_err <= 1'b1;
          end
          if (bus.tx_ready) begin
            bus.tx_data <= tx_lo;
            state       <= TXL;
          end
        end

        TXL: begin
          if (bus.rx_valid) begin
            bus.pkt_err <= 1'b1;
          end
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_ctrl.sv
// ---------------------------------------------------------------------------
// tb_perceptron_ctrl
//   Directed self-checking bench for perceptron_ctrl. A negedge monitor logs
//   every strobe and TX transfer; the main sequence compares those logs and
//   the live outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_perceptron_ctrl;

  localparam int TO = 64;

  logic clk;
  logic nRst;

  perceptron_ctrl_if bus_if ();

  perceptron_ctrl #(
    .ADDR   (8'd100),
    .N_IN   (4),
    .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int w_cnt = 0, x_cnt = 0, start_cnt = 0, err_cnt = 0, txv_cnt = 0, tx_cnt = 0;
  logic [1:0] w_idx_log [64];
  logic [7:0] w_dat_log [64];
  logic [1:0] x_idx_log [64];
  logic [7:0] x_dat_log [64];
  logic [7:0] tx_log    [64];

  // Monitor samples mid-cycle; inputs change just after posedge, so a
  // tx_valid & tx_ready seen here is the transfer taken at the next posedge.
  always @(negedge clk) begin
    if (nRst) begin
      if (bus_if.w_we) begin
        if (w_cnt < 64) begin
          w_idx_log[w_cnt] = bus_if.wr_idx;
          w_dat_log[w_cnt] = bus_if.wr_data;
        end
        w_cnt++;
      end
      if (bus_if.x_we) begin
        if (x_cnt < 64) begin
          x_idx_log[x_cnt] = bus_if.wr_idx;
          x_dat_log[x_cnt] = bus_if.wr_data;
        end
        x_cnt++;
      end
      if (bus_if.calc_start) start_cnt++;
      if (bus_if.pkt_err) err_cnt++;
      if (bus_if.tx_valid) txv_cnt++;
      if (bus_if.tx_valid && bus_if.tx_ready) begin
        if (tx_cnt < 64) tx_log[tx_cnt] = bus_if.tx_data;
        tx_cnt++;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    @(posedge clk);
    #2;
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    @(posedge clk);
    #2;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] op, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    apply_stimulus(a);
    apply_stimulus(op);
    apply_stimulus(d0);
    apply_stimulus(d1);
    apply_stimulus(d2);
    apply_stimulus(d3);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check_output({tag, " tx_valid"},   32'(bus_if.tx_valid),   32'h0);
    check_output({tag, " tx_data"},    32'(bus_if.tx_data),    32'h0);
    check_output({tag, " w_we"},       32'(bus_if.w_we),       32'h0);
    check_output({tag, " x_we"},       32'(bus_if.x_we),       32'h0);
    check_output({tag, " wr_idx"},     32'(bus_if.wr_idx),     32'h0);
    check_output({tag, " wr_data"},    32'(bus_if.wr_data),    32'h0);
    check_output({tag, " calc_start"}, 32'(bus_if.calc_start), 32'h0);
    check_output({tag, " busy"},       32'(bus_if.busy),       32'h0);
    check_output({tag, " pkt_err"},    32'(bus_if.pkt_err),    32'h0);
  endtask

  int wb, xb, sb, eb, vb, tb_;

  initial begin
    nRst               = 1'b0;
    bus_if.rx_valid    = 1'b0;
    bus_if.rx_data     = 8'h00;
    bus_if.tx_ready    = 1'b0;
    bus_if.calc_done   = 1'b0;
    bus_if.calc_result = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #2;
    nRst = 1'b1;

    // Test 1: weight load
    $display("[TB] test 1: weight packet");
    wb = w_cnt; xb = x_cnt; sb = start_cnt; vb = txv_cnt;
    send_pkt(8'd100, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4);
    idle_cycles(3);
    check_output("t1 w count", 32'(w_cnt - wb), 32'd4);
    check_output("t1 x count", 32'(x_cnt - xb), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_output("t1 w idx",  32'(w_idx_log[wb + i]), 32'(i));
      check_output("t1 w data", 32'(w_dat_log[wb + i]), 32'(i + 1));
    end
    check_output("t1 calc_start", 32'(start_cnt - sb), 32'd0);
    check_output("t1 tx_valid",   32'(txv_cnt - vb),   32'd0);

    // Stray calc_done while idle must not trigger a transmission
    @(posedge clk); #2; bus_if.calc_done = 1'b1; bus_if.calc_result = 16'hBEEF;
    @(posedge clk); #2; bus_if.calc_done = 1'b0;
    @(negedge clk);
    check_output("stray calc_done tx_valid", 32'(bus_if.tx_valid), 32'h0);

    // Test 2: input load, calculation and result transmission
    $display("[TB] test 2: input packet and result");
    wb = w_cnt; xb = x_cnt; sb = start_cnt; eb = err_cnt; tb_ = tx_cnt;
    send_pkt(8'd100, 8'd1, 8'd10, 8'd20, 8'd30, 8'd40);
    idle_cycles(3);
    check_output("t2 x count", 32'(x_cnt - xb), 32'd4);
    check_output("t2 w count", 32'(w_cnt - wb), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_output("t2 x idx",  32'(x_idx_log[xb + i]), 32'(i));
      check_output("t2 x data", 32'(x_dat_log[xb + i]), 32'(10 * (i + 1)));
    end
    check_output("t2 calc_start", 32'(start_cnt - sb), 32'd1);
    check_output("t2 busy",       32'(bus_if.busy),    32'h1);
    bus_if.calc_done   = 1'b1;
    bus_if.calc_result = 16'h1234;
    @(posedge clk); #2;
    bus_if.calc_done   = 1'b0;
    bus_if.calc_result = 16'h0000;
    @(negedge clk);
    check_output("t2 txh valid", 32'(bus_if.tx_valid), 32'h1);
    check_output("t2 txh data",  32'(bus_if.tx_data),  32'h12);

    // Test 6a: byte arriving while TXH is stalled
    apply_stimulus(8'h55);
    idle_cycles(1);
    @(negedge clk);
    check_output("t6 busy pkt_err", 32'(err_cnt - eb),   32'd1);
    check_output("t6 tx_data held", 32'(bus_if.tx_data), 32'h12);
    check_output("t6 tx_valid held", 32'(bus_if.tx_valid), 32'h1);

    @(posedge clk); #2; bus_if.tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("t2 txl data", 32'(bus_if.tx_data), 32'h34);
    @(posedge clk); #2; bus_if.tx_ready = 1'b0;
    @(negedge clk);
    check_output("t2 tx count",   32'(tx_cnt - tb_),     32'd2);
    check_output("t2 tx byte0",   32'(tx_log[tb_]),      32'h12);
    check_output("t2 tx byte1",   32'(tx_log[tb_ + 1]),  32'h34);
    check_output("t2 tx_valid end", 32'(bus_if.tx_valid), 32'h0);
    check_output("t2 busy end",   32'(bus_if.busy),      32'h0);

    // Test 3: foreign packet skipped, then a normal packet
    $display("[TB] test 3: foreign address");
    wb = w_cnt; xb = x_cnt; eb = err_cnt;
    send_pkt(8'd55, 8'd0, 8'd9, 8'd9, 8'd9, 8'd9);
    send_pkt(8'd100, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4);
    idle_cycles(3);
    check_output("t3 w count", 32'(w_cnt - wb), 32'd4);
    check_output("t3 x count", 32'(x_cnt - xb), 32'd0);
    check_output("t3 first data", 32'(w_dat_log[wb]),  32'd1);
    check_output("t3 first idx",  32'(w_idx_log[wb]),  32'd0);
    check_output("t3 no pkt_err", 32'(err_cnt - eb),   32'd0);

    // Test 4: bad opcode
    $display("[TB] test 4: bad opcode");
    wb = w_cnt; xb = x_cnt; eb = err_cnt;
    send_pkt(8'd100, 8'd7, 8'd11, 8'd12, 8'd13, 8'd14);
    idle_cycles(3);
    check_output("t4 pkt_err",  32'(err_cnt - eb), 32'd1);
    check_output("t4 w count",  32'(w_cnt - wb),   32'd0);
    check_output("t4 x count",  32'(x_cnt - xb),   32'd0);
    send_pkt(8'd100, 8'd0, 8'd5, 8'd6, 8'd7, 8'd8);
    idle_cycles(3);
    check_output("t4 next w count", 32'(w_cnt - wb),   32'd4);
    check_output("t4 next idx",     32'(w_idx_log[wb]), 32'd0);
    check_output("t4 next data",    32'(w_dat_log[wb]), 32'd5);

    // Test 5: inter-byte timeout
    $display("[TB] test 5: timeout");
    wb = w_cnt; eb = err_cnt;
    apply_stimulus(8'd100);
    apply_stimulus(8'd0);
    apply_stimulus(8'd1);
    idle_cycles(TO + 10);
    check_output("t5 pkt_err",  32'(err_cnt - eb), 32'd1);
    check_output("t5 w count",  32'(w_cnt - wb),   32'd1);
    send_pkt(8'd100, 8'd0, 8'd21, 8'd22, 8'd23, 8'd24);
    idle_cycles(3);
    check_output("t5 next w count", 32'(w_cnt - wb),       32'd5);
    check_output("t5 next idx",     32'(w_idx_log[wb + 1]), 32'd0);
    check_output("t5 next data",    32'(w_dat_log[wb + 1]), 32'd21);
    check_output("t5 last idx",     32'(w_idx_log[wb + 4]), 32'd3);

    // Test 6b: reset in the middle of a data phase
    $display("[TB] test 6: reset mid-packet");
    apply_stimulus(8'd100);
    apply_stimulus(8'd0);
    apply_stimulus(8'd5);
    nRst = 1'b0;
    @(posedge clk);
    check_all_zero("t6 reset");
    @(posedge clk); #2;
    nRst = 1'b1;
    wb = w_cnt;
    send_pkt(8'd100, 8'd0, 8'd7, 8'd8, 8'd9, 8'd10);
    idle_cycles(3);
    check_output("t6 after reset count", 32'(w_cnt - wb),   32'd4);
    check_output("t6 after reset idx",   32'(w_idx_log[wb]), 32'd0);
    check_output("t6 after reset data",  32'(w_dat_log[wb]), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
